// File: rtl/alarm_ctrl.sv
// Alarm controller: stores an alarm time, watches the running clock for a
// match, rings for a bounded number of cycles and supports stop/snooze.
module alarm_ctrl #(
  parameter int RING_CYCLES = 8,
  parameter int SNOOZE_MIN  = 2,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hour,
  input  logic [3:0] min,
  input  logic [4:0] sec,
  input  logic       alarm_en,
  input  logic       set_valid,
  input  logic [2:0] set_hour,
  input  logic [3:0] set_min,
  output logic       set_ready,
  output logic       set_err,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic [1:0] state,
  output logic [2:0] alarm_hour,
  output logic [3:0] alarm_min,
  output logic [2:0] snooze_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_ring;
  logic       r_set_err;
  logic [2:0] r_snooze_cnt;
  logic [2:0] r_alarm_h;
  logic [3:0] r_alarm_m;
  logic [2:0] r_tgt_h;
  logic [3:0] r_tgt_m;
  logic [7:0] r_ring_cnt;

  state_t     w_state_nxt;
  logic [2:0] w_snooze_cnt_nxt;
  logic [2:0] w_alarm_h_nxt;
  logic [3:0] w_alarm_m_nxt;
  logic [2:0] w_tgt_h_nxt;
  logic [3:0] w_tgt_m_nxt;
  logic [7:0] w_ring_cnt_nxt;
  logic       w_set_err_nxt;

  logic       w_wr;
  logic       w_wr_ok;
  logic       w_match;
  logic       w_snz_cap;
  logic [4:0] w_snz_sum;
  logic [2:0] w_snz_h;
  logic [3:0] w_snz_m;

  // Ready depends on state only so a write never waits on input timing.
  assign set_ready  = (r_state != S_RINGING);
  assign w_wr       = set_valid && set_ready;
  assign w_wr_ok    = w_wr && (set_hour <= 3'd5) && (set_min <= 4'd10);
  assign w_match    = (hour == r_tgt_h) && (min == r_tgt_m) && (sec == 5'd0);
  assign w_snz_cap  = (r_snooze_cnt >= 3'(MAX_SNOOZE));

  // Snooze target: current hour:minute plus SNOOZE_MIN with minute mod 11,
  // hour mod 6. SNOOZE_MIN <= 10 and min <= 10 so at most one wrap occurs.
  always_comb begin
    w_snz_sum = {1'b0, min} + 5'(SNOOZE_MIN);
    w_snz_h   = hour;
    w_snz_m   = w_snz_sum[3:0];
    if (w_snz_sum >= 5'd11) begin
      w_snz_m = 4'(w_snz_sum - 5'd11);
      w_snz_h = (hour >= 3'd5) ? 3'd0 : hour + 3'd1;
    end
  end

  // Next-state, counters, stored alarm time and target selection.
  always_comb begin
    w_state_nxt      = r_state;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_alarm_h_nxt    = r_alarm_h;
    w_alarm_m_nxt    = r_alarm_m;
    w_ring_cnt_nxt   = r_ring_cnt;
    w_set_err_nxt    = w_wr && !w_wr_ok;
    w_tgt_h_nxt      = r_tgt_h;
    w_tgt_m_nxt      = r_tgt_m;

    // A good write updates the alarm and abandons any snooze in progress.
    if (w_wr_ok) begin
      w_alarm_h_nxt    = set_hour;
      w_alarm_m_nxt    = set_min;
      w_snooze_cnt_nxt = 3'd0;
      if (r_state == S_SNOOZE) w_state_nxt = S_ARMED;
    end

    case (r_state)
      S_IDLE: begin
        if (alarm_en) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_match) begin
          w_state_nxt    = S_RINGING;
          w_ring_cnt_nxt = 8'(RING_CYCLES - 1);
        end
      end
      S_SNOOZE: begin
        if (stop) begin
          w_state_nxt      = S_ARMED;
          w_snooze_cnt_nxt = 3'd0;
        end else if (w_match) begin
          // Match was evaluated against the old target, so it wins over a write.
          w_state_nxt    = S_RINGING;
          w_ring_cnt_nxt = 8'(RING_CYCLES - 1);
        end
      end
      S_RINGING: begin
        if (stop || (snooze && w_snz_cap)) begin
          w_state_nxt      = S_ARMED;
          w_snooze_cnt_nxt = 3'd0;
        end else if (snooze) begin
          w_state_nxt      = S_SNOOZE;
          w_snooze_cnt_nxt = r_snooze_cnt + 3'd1;
        end else if (r_ring_cnt == 8'd0) begin
          w_state_nxt      = S_ARMED;
          w_snooze_cnt_nxt = 3'd0;
        end else begin
          w_ring_cnt_nxt = r_ring_cnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Disarm overrides everything else.
    if (!alarm_en) begin
      w_state_nxt      = S_IDLE;
      w_snooze_cnt_nxt = 3'd0;
    end

    // Target tracks the alarm time everywhere except while snoozing.
    if (w_state_nxt == S_SNOOZE) begin
      if (r_state == S_RINGING) begin
        w_tgt_h_nxt = w_snz_h;
        w_tgt_m_nxt = w_snz_m;
      end
    end else begin
      w_tgt_h_nxt = w_alarm_h_nxt;
      w_tgt_m_nxt = w_alarm_m_nxt;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ring       <= 1'b0;
      r_set_err    <= 1'b0;
      r_snooze_cnt <= 3'd0;
      r_alarm_h    <= 3'd0;
      r_alarm_m    <= 4'd0;
      r_tgt_h      <= 3'd0;
      r_tgt_m      <= 4'd0;
      r_ring_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ring       <= (w_state_nxt == S_RINGING);
      r_set_err    <= w_set_err_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_alarm_h    <= w_alarm_h_nxt;
      r_alarm_m    <= w_alarm_m_nxt;
      r_tgt_h      <= w_tgt_h_nxt;
      r_tgt_m      <= w_tgt_m_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
    end
  end

  assign state      = r_state;
  assign ring       = r_ring;
  assign set_err    = r_set_err;
  assign snooze_cnt = r_snooze_cnt;
  assign alarm_hour = r_alarm_h;
  assign alarm_min  = r_alarm_m;

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_CYCLES, default 8: cycles ring stays asserted without stop/snooze; range 1..255.
REQ-002 Parameter SNOOZE_MIN, default 2: minutes added per snooze; range 1..10.
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event; range 1..7.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 hour  in  3  current hour from the time counter, 0..5.
REQ-007 min  in  4  current minute, 0..10.
REQ-008 sec  in  5  current second, 0..20.
REQ-009 alarm_en  in  1  level; 0 disarms.
REQ-010 set_valid  in  1  alarm-time write request.
REQ-011 set_hour  in  3  requested alarm hour.
REQ-012 set_min  in  4  requested alarm minute.
REQ-013 set_ready  out  1  write can be accepted this cycle.
REQ-014 set_err  out  1  one-cycle pulse: accepted write was out of range.
REQ-015 stop  in  1  acknowledge ring.
REQ-016 snooze  in  1  defer ring.
REQ-017 ring  out  1  alarm sounding.
REQ-018 state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-019 alarm_hour  out  3 / alarm_min  out  4  stored alarm time.
REQ-020 snooze_cnt  out  3  snoozes used this event.

Function
REQ-021 All outputs registered; no combinational input-to-output path except set_ready (decoded from state only).
REQ-022 Stored target (tgt_h, tgt_m) internal; equals alarm time except in SNOOZE.
REQ-023 Match = hour==tgt_h && min==tgt_m && sec==0; evaluated every cycle, one cycle wide per minute by construction.
REQ-024 IDLE -> ARMED when alarm_en=1.
REQ-025 ARMED: match -> RINGING; ring=1 from the edge after the match cycle (latency 1).
REQ-026 RINGING: ring cycle counter loads RING_CYCLES-1 on entry, decrements each cycle; at 0 with no stop/snooze -> ARMED, ring=0, snooze_cnt=0.
REQ-027 RINGING, stop=1 -> ARMED, ring=0 next edge, snooze_cnt=0, tgt reloaded from alarm time.
REQ-028 RINGING, snooze=1 and snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, tgt = current time (hour,min) + SNOOZE_MIN.
REQ-029 Snooze add: minute modulo 11; carry increments hour modulo 6 (e.g. 5:10 +2 -> 0:01).
REQ-030 RINGING, snooze=1 with snooze_cnt==MAX_SNOOZE: treated as stop.
REQ-031 SNOOZE: match -> RINGING (REQ-025 latency); stop -> ARMED, snooze_cnt=0, tgt reloaded.
REQ-032 Priority within a cycle: alarm_en=0 > stop > snooze > ring timeout > match.
REQ-033 alarm_en=0 in any state -> IDLE next edge, ring=0, snooze_cnt=0, tgt reloaded.
REQ-034 set_ready=1 in IDLE, ARMED, SNOOZE; 0 in RINGING. Transfer occurs on valid&&ready at the edge.
REQ-035 Accepted write with set_hour<=5 and set_min<=10: alarm time and tgt load next edge, snooze_cnt=0; SNOOZE -> ARMED.
REQ-036 Accepted write out of range: no state/time change, set_err=1 for exactly one cycle.
REQ-037 Write and match in same cycle: match uses old tgt (transition taken), new time still stored; in ARMED state ends RINGING with new tgt.
REQ-038 set_valid while set_ready=0: ignored, not queued.

Reset
REQ-039 rst=0 asynchronously forces: state=IDLE, ring=0, set_err=0, snooze_cnt=0, alarm_hour=0, alarm_min=0, tgt=0:00, ring counter=0.
REQ-040 Reset deassertion mid-ring: ring remains 0 until a new match; no pending event retained.

Verification
REQ-041 Write 2:05, alarm_en=1, sweep time to 2:05:00 -> ring=1 next cycle, held 8 cycles, then state=ARMED, ring=0.
REQ-042 Ringing at 5:10:00, snooze -> state=SNOOZE, snooze_cnt=1, re-rings at 0:01:00; four snoozes -> fourth acts as stop, snooze_cnt=0.
REQ-043 Write set_hour=6, set_min=3 -> set_err one cycle, alarm_hour/min unchanged.
REQ-044 stop and snooze same cycle in RINGING -> ARMED, ring=0, snooze_cnt=0.
REQ-045 alarm_en dropped during RINGING -> IDLE, ring=0 next edge; set_valid during RINGING ignored (set_ready=0).
REQ-046 rst pulsed low between clock edges during RINGING -> ring=0 immediately, all REQ-039 values.
